// File: rtl/frame2axi_stream_pkg.sv
// Shared definitions for the frame-to-AXI4-Stream bridge: FSM encoding,
// FIFO sizing and the width of the position counters.
package frame2axi_stream_pkg;

    localparam int             FIFO_DEPTH    = 2;
    localparam logic [1:0]     FIFO_CNT_FULL = 2'd2;
    localparam int             CNT_W         = 12;
    localparam logic [CNT_W-1:0] CNT_MAX     = '1;

    typedef enum logic {
        IDLE   = 1'b0,
        ACTIVE = 1'b1
    } frm_state_t;

    // Increment that sticks at the counter ceiling instead of wrapping
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == CNT_MAX) ? v : v + 12'd1;
    endfunction

endpackage

// File: rtl/frm_skid_fifo.sv
// Two-entry FIFO used as the skid buffer between the frame input and the
// stream output. The head entry drives rd_data directly; not_full is a pure
// function of the registered count so the input ready never sees tready.
module frm_skid_fifo
    import frame2axi_stream_pkg::*;
#(
    parameter int WIDTH = 26
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    output logic [WIDTH-1:0] rd_data,
    output logic             not_empty,
    output logic             not_full
);

    logic [WIDTH-1:0] mem [FIFO_DEPTH];
    logic             wr_ptr;
    logic             rd_ptr;
    logic [1:0]       count;
    logic             do_wr;
    logic             do_rd;

    assign do_wr     = wr_en && (count != FIFO_CNT_FULL);
    assign do_rd     = rd_en && (count != 2'd0);
    assign rd_data   = mem[rd_ptr];
    assign not_empty = (count != 2'd0);
    assign not_full  = (count != FIFO_CNT_FULL);

    // Storage, pointers and occupancy; a simultaneous write and read keeps count
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= 2'd0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (do_wr) begin
                mem[wr_ptr] <= wr_data;
                wr_ptr      <= ~wr_ptr;
            end
            if (do_rd) begin
                rd_ptr <= ~rd_ptr;
            end
            case ({do_wr, do_rd})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/frame2axi_stream.sv
// Frame interface to AXI4-Stream video bridge. Beats are dropped until a
// start-of-frame is seen, then forwarded through a two-entry skid FIFO with
// sof mapped to tuser and eol mapped to tlast. Line length, frame height and
// premature start-of-frame are flagged in sticky error bits.
module frame2axi_stream
    import frame2axi_stream_pkg::*;
#(
    parameter int DATA_WIDTH = 24
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [11:0]           cfg_img_w,
    input  logic [11:0]           cfg_img_h,
    input  logic                  err_clr,
    input  logic                  m_frm_val,
    output logic                  m_frm_rdy,
    input  logic [DATA_WIDTH-1:0] m_frm_data,
    input  logic                  m_frm_sof,
    input  logic                  m_frm_eof,
    input  logic                  m_frm_sol,
    input  logic                  m_frm_eol,
    output logic                  s_axi_stream_tvalid,
    input  logic                  s_axi_stream_tready,
    output logic [DATA_WIDTH-1:0] s_axi_stream_tdata,
    output logic                  s_axi_stream_tuser,
    output logic                  s_axi_stream_tlast,
    output logic                  frm_done,
    output logic                  err_line_len,
    output logic                  err_frm_h,
    output logic                  err_early_sof
);

    localparam int FW = DATA_WIDTH + 2;

    frm_state_t       state;
    frm_state_t       state_nxt;
    logic [CNT_W-1:0] pix_cnt;
    logic [CNT_W-1:0] line_cnt;
    logic [CNT_W-1:0] pix_idx;
    logic [CNT_W-1:0] line_idx;
    logic             in_acc;
    logic             out_xfer;
    logic             fifo_wr;
    logic             done_set;
    logic             fifo_not_empty;
    logic             fifo_not_full;
    logic [FW-1:0]    fifo_head;
    logic             line_len_hit;
    logic             frm_h_hit;
    logic             early_sof_hit;
    logic             sol_unused;

    // Start-of-line carries no information the counters need
    assign sol_unused = m_frm_sol;

    assign in_acc    = m_frm_val & m_frm_rdy;
    assign out_xfer  = s_axi_stream_tvalid & s_axi_stream_tready;
    assign m_frm_rdy = fifo_not_full;

    // Position of the beat being accepted; a sof beat is always pixel 0, line 0
    assign pix_idx  = m_frm_sof ? '0 : pix_cnt;
    assign line_idx = m_frm_sof ? '0 : line_cnt;

    assign line_len_hit  = in_acc && m_frm_eol && (pix_idx != (cfg_img_w - 12'd1));
    assign frm_h_hit     = in_acc && m_frm_eof && (line_idx != (cfg_img_h - 12'd1));
    assign early_sof_hit = in_acc && m_frm_sof && (state == ACTIVE);

    // FSM state register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // FSM next-state: a frame opens on sof and closes on eof (possibly the same beat)
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (in_acc && m_frm_sof) state_nxt = m_frm_eof ? IDLE : ACTIVE;
            ACTIVE:  if (in_acc && m_frm_eof) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // FSM outputs: which accepted beats enter the FIFO and when a frame completes
    always_comb begin
        fifo_wr  = 1'b0;
        done_set = 1'b0;
        case (state)
            IDLE: begin
                fifo_wr  = in_acc && m_frm_sof;
                done_set = in_acc && m_frm_sof && m_frm_eof;
            end
            ACTIVE: begin
                fifo_wr  = in_acc;
                done_set = in_acc && m_frm_eof;
            end
            default: begin
                fifo_wr  = 1'b0;
                done_set = 1'b0;
            end
        endcase
    end

    // Pixel/line position tracking on every accepted beat
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pix_cnt  <= '0;
            line_cnt <= '0;
        end else if (in_acc) begin
            if (m_frm_eol) begin
                pix_cnt  <= '0;
                line_cnt <= sat_inc(line_idx);
            end else begin
                pix_cnt  <= sat_inc(pix_idx);
                line_cnt <= line_idx;
            end
        end
    end

    // Sticky error flags and the frame-done pulse; a new error wins over err_clr
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            err_line_len  <= 1'b0;
            err_frm_h     <= 1'b0;
            err_early_sof <= 1'b0;
            frm_done      <= 1'b0;
        end else begin
            frm_done <= done_set;
            if (line_len_hit)       err_line_len <= 1'b1;
            else if (err_clr)       err_line_len <= 1'b0;
            if (frm_h_hit)          err_frm_h <= 1'b1;
            else if (err_clr)       err_frm_h <= 1'b0;
            if (early_sof_hit)      err_early_sof <= 1'b1;
            else if (err_clr)       err_early_sof <= 1'b0;
        end
    end

    frm_skid_fifo #(
        .WIDTH (FW)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .wr_en     (fifo_wr),
        .wr_data   ({m_frm_data, m_frm_sof, m_frm_eol}),
        .rd_en     (out_xfer),
        .rd_data   (fifo_head),
        .not_empty (fifo_not_empty),
        .not_full  (fifo_not_full)
    );

    assign s_axi_stream_tvalid = fifo_not_empty;
    assign s_axi_stream_tdata  = fifo_head[FW-1:2];
    assign s_axi_stream_tuser  = fifo_head[1];
    assign s_axi_stream_tlast  = fifo_head[0];

endmodule

// File: tb/tb_frame2axi_stream.sv
// Testbench for frame2axi_stream: a cycle-by-cycle vector table for the
// error/counter behaviour, plus frame-level sequences checked against a
// capture queue of output beats.
module tb_frame2axi_stream;

    localparam int DW = 24;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [11:0]   cfg_img_w;
    logic [11:0]   cfg_img_h;
    logic          err_clr;
    logic          m_frm_val;
    logic          m_frm_rdy;
    logic [DW-1:0] m_frm_data;
    logic          m_frm_sof;
    logic          m_frm_eof;
    logic          m_frm_sol;
    logic          m_frm_eol;
    logic          s_axi_stream_tvalid;
    logic          s_axi_stream_tready;
    logic [DW-1:0] s_axi_stream_tdata;
    logic          s_axi_stream_tuser;
    logic          s_axi_stream_tlast;
    logic          frm_done;
    logic          err_line_len;
    logic          err_frm_h;
    logic          err_early_sof;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    frame2axi_stream #(
        .DATA_WIDTH (DW)
    ) dut (
        .clk                 (clk),
        .rst_n               (rst_n),
        .cfg_img_w           (cfg_img_w),
        .cfg_img_h           (cfg_img_h),
        .err_clr             (err_clr),
        .m_frm_val           (m_frm_val),
        .m_frm_rdy           (m_frm_rdy),
        .m_frm_data          (m_frm_data),
        .m_frm_sof           (m_frm_sof),
        .m_frm_eof           (m_frm_eof),
        .m_frm_sol           (m_frm_sol),
        .m_frm_eol           (m_frm_eol),
        .s_axi_stream_tvalid (s_axi_stream_tvalid),
        .s_axi_stream_tready (s_axi_stream_tready),
        .s_axi_stream_tdata  (s_axi_stream_tdata),
        .s_axi_stream_tuser  (s_axi_stream_tuser),
        .s_axi_stream_tlast  (s_axi_stream_tlast),
        .frm_done            (frm_done),
        .err_line_len        (err_line_len),
        .err_frm_h           (err_frm_h),
        .err_early_sof       (err_early_sof)
    );

    typedef struct {
        logic [DW-1:0] data;
        logic          user;
        logic          last;
    } beat_t;

    typedef struct {
        logic          val, sof, eof, sol, eol, clr;
        logic [DW-1:0] data;
        logic          e_tvalid;
        logic [DW-1:0] e_tdata;
        logic          e_tuser, e_tlast, e_done, e_line, e_h, e_esof;
    } vec_t;

    beat_t         got_q[$];
    vec_t          vecs[$];
    int            done_cnt  = 0;
    int            stab_bad  = 0;
    int            rdy_bad   = 0;
    int            mcnt      = 0;
    bit            mact      = 1'b0;
    bit            mon_rdy   = 1'b0;
    bit            toggle_en = 1'b0;
    logic          hold_v    = 1'b0;
    logic [DW+1:0] hold_val  = '0;

    // Output monitor: captures transfers, counts done pulses, watches stall
    // stability and compares input ready against an occupancy model
    always @(negedge clk) begin
        logic acc, wr, rd;
        if (rst_n === 1'b1) begin
            if (s_axi_stream_tvalid && s_axi_stream_tready)
                got_q.push_back('{s_axi_stream_tdata, s_axi_stream_tuser, s_axi_stream_tlast});
            if (frm_done === 1'b1) done_cnt++;
            if (hold_v && (s_axi_stream_tvalid !== 1'b1 ||
                {s_axi_stream_tdata, s_axi_stream_tuser, s_axi_stream_tlast} !== hold_val))
                stab_bad++;
        end
        hold_v   = (rst_n === 1'b1) && s_axi_stream_tvalid && !s_axi_stream_tready;
        hold_val = {s_axi_stream_tdata, s_axi_stream_tuser, s_axi_stream_tlast};
        if (mon_rdy) begin
            if (m_frm_rdy !== (mcnt < 2)) rdy_bad++;
            acc = m_frm_val && m_frm_rdy;
            wr  = acc && (mact || m_frm_sof);
            rd  = s_axi_stream_tvalid && s_axi_stream_tready;
            mcnt = mcnt + int'(wr) - int'(rd);
            if (wr) mact = !m_frm_eof;
        end else begin
            mcnt = 0;
            mact = 1'b0;
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic doReset();
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    // Present one beat and hold it until it is accepted (bounded wait)
    task automatic applyStimulus(input logic [DW-1:0] d, input logic sof, input logic eof,
                                 input logic sol, input logic eol);
        int waited = 0;
        m_frm_val  = 1'b1;
        m_frm_data = d;
        m_frm_sof  = sof;
        m_frm_eof  = eof;
        m_frm_sol  = sol;
        m_frm_eol  = eol;
        @(negedge clk);
        while (m_frm_rdy !== 1'b1 && waited < 100) begin
            @(negedge clk);
            waited++;
        end
        if (waited >= 100) checkOutput("accept_timeout", 32'(waited), 32'd0);
        @(posedge clk);
        #1;
        m_frm_val = 1'b0;
        m_frm_sof = 1'b0;
        m_frm_eof = 1'b0;
        m_frm_sol = 1'b0;
        m_frm_eol = 1'b0;
    endtask

    task automatic sendFrame(input int w, input int h, input logic [DW-1:0] base);
        for (int l = 0; l < h; l++) begin
            for (int p = 0; p < w; p++) begin
                applyStimulus(base + DW'(l * 16 + p), (l == 0 && p == 0),
                              (l == h - 1 && p == w - 1), (p == 0), (p == w - 1));
            end
        end
    endtask

    task automatic waitBeats(input int target);
        int c = 0;
        while (got_q.size() < target && c < 200) begin
            @(posedge clk);
            c++;
        end
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic checkFrame(input string tag, input int base_idx, input int w, input int h,
                              input logic [DW-1:0] base);
        int n = w * h;
        checkOutput({tag, "_beats"}, 32'(got_q.size() - base_idx), 32'(n));
        for (int i = 0; i < n; i++) begin
            if (base_idx + i < got_q.size()) begin
                beat_t b = got_q[base_idx + i];
                int    l = i / w;
                int    p = i % w;
                checkOutput({tag, "_data"}, 32'(b.data), 32'(base + DW'(l * 16 + p)));
                checkOutput({tag, "_tuser"}, 32'(b.user), 32'(i == 0));
                checkOutput({tag, "_tlast"}, 32'(b.last), 32'(p == w - 1));
            end
        end
    endtask

    task automatic checkErrorsClear(input string tag);
        checkOutput({tag, "_err_line_len"}, 32'(err_line_len), 32'd0);
        checkOutput({tag, "_err_frm_h"}, 32'(err_frm_h), 32'd0);
        checkOutput({tag, "_err_early_sof"}, 32'(err_early_sof), 32'd0);
    endtask

    task automatic addVec(input logic val, input logic sof, input logic eof, input logic sol,
                          input logic eol, input logic clr, input logic [DW-1:0] data,
                          input logic e_tvalid, input logic [DW-1:0] e_tdata, input logic e_tuser,
                          input logic e_tlast, input logic e_done, input logic e_line,
                          input logic e_h, input logic e_esof);
        vecs.push_back('{val, sof, eof, sol, eol, clr, data, e_tvalid, e_tdata, e_tuser,
                         e_tlast, e_done, e_line, e_h, e_esof});
    endtask

    initial begin
        int base;
        int d0;
        rst_n               = 1'b1;
        cfg_img_w           = 12'd4;
        cfg_img_h           = 12'd2;
        err_clr             = 1'b0;
        m_frm_val           = 1'b0;
        m_frm_data          = '0;
        m_frm_sof           = 1'b0;
        m_frm_eof           = 1'b0;
        m_frm_sol           = 1'b0;
        m_frm_eol           = 1'b0;
        s_axi_stream_tready = 1'b1;

        // Reset state
        doReset();
        checkOutput("rst_tvalid", 32'(s_axi_stream_tvalid), 32'd0);
        checkOutput("rst_tdata", 32'(s_axi_stream_tdata), 32'd0);
        checkOutput("rst_tuser", 32'(s_axi_stream_tuser), 32'd0);
        checkOutput("rst_tlast", 32'(s_axi_stream_tlast), 32'd0);
        checkOutput("rst_done", 32'(frm_done), 32'd0);
        checkOutput("rst_rdy", 32'(m_frm_rdy), 32'd1);
        checkErrorsClear("rst");

        // Vector table: val sof eof sol eol clr data | tvalid tdata tuser tlast done line h esof
        addVec(1,1,0,1,0,0,'hA0, 1,'hA0,1,0, 0,0,0,0);
        addVec(1,0,0,0,0,0,'hA1, 1,'hA1,0,0, 0,0,0,0);
        addVec(1,0,0,0,1,0,'hA2, 1,'hA2,0,1, 0,1,0,0);  // short line of 3
        addVec(0,0,0,0,0,0,'h00, 0,'h00,0,0, 0,1,0,0);  // error held
        addVec(0,0,0,0,0,1,'h00, 0,'h00,0,0, 0,0,0,0);  // cleared
        addVec(1,0,0,1,0,0,'hB0, 1,'hB0,0,0, 0,0,0,0);
        addVec(1,0,0,0,0,0,'hB1, 1,'hB1,0,0, 0,0,0,0);
        addVec(1,1,0,0,0,0,'hC0, 1,'hC0,1,0, 0,0,0,1);  // sof at pixel 2 of line 1
        addVec(1,0,0,0,0,0,'hC1, 1,'hC1,0,0, 0,0,0,1);
        addVec(1,0,0,0,0,0,'hC2, 1,'hC2,0,0, 0,0,0,1);
        addVec(1,0,0,0,1,0,'hC3, 1,'hC3,0,1, 0,0,0,1);  // restarted counters: full line
        addVec(1,0,0,1,0,0,'hD0, 1,'hD0,0,0, 0,0,0,1);
        addVec(1,0,0,0,0,0,'hD1, 1,'hD1,0,0, 0,0,0,1);
        addVec(1,0,0,0,0,0,'hD2, 1,'hD2,0,0, 0,0,0,1);
        addVec(1,0,1,0,1,0,'hD3, 1,'hD3,0,1, 1,0,0,1);  // eof on line 1: height ok
        addVec(0,0,0,0,0,0,'h00, 0,'h00,0,0, 0,0,0,1);
        addVec(1,1,1,1,1,0,'hE0, 1,'hE0,1,1, 1,1,1,1);  // single-beat frame
        addVec(0,0,0,0,0,1,'h00, 0,'h00,0,0, 0,0,0,0);
        addVec(1,1,1,1,1,1,'hF0, 1,'hF0,1,1, 1,1,1,0);  // set beats clear
        addVec(0,0,0,0,0,1,'h00, 0,'h00,0,0, 0,0,0,0);
        addVec(1,0,0,0,0,0,'h55, 0,'h00,0,0, 0,0,0,0);  // idle junk dropped

        doReset();
        for (int i = 0; i < vecs.size(); i++) begin
            m_frm_val  = vecs[i].val;
            m_frm_sof  = vecs[i].sof;
            m_frm_eof  = vecs[i].eof;
            m_frm_sol  = vecs[i].sol;
            m_frm_eol  = vecs[i].eol;
            m_frm_data = vecs[i].data;
            err_clr    = vecs[i].clr;
            @(posedge clk);
            #1;
            checkOutput($sformatf("tbl%0d_tvalid", i), 32'(s_axi_stream_tvalid), 32'(vecs[i].e_tvalid));
            if (vecs[i].e_tvalid) begin
                checkOutput($sformatf("tbl%0d_tdata", i), 32'(s_axi_stream_tdata), 32'(vecs[i].e_tdata));
                checkOutput($sformatf("tbl%0d_tuser", i), 32'(s_axi_stream_tuser), 32'(vecs[i].e_tuser));
                checkOutput($sformatf("tbl%0d_tlast", i), 32'(s_axi_stream_tlast), 32'(vecs[i].e_tlast));
            end
            checkOutput($sformatf("tbl%0d_done", i), 32'(frm_done), 32'(vecs[i].e_done));
            checkOutput($sformatf("tbl%0d_err_line_len", i), 32'(err_line_len), 32'(vecs[i].e_line));
            checkOutput($sformatf("tbl%0d_err_frm_h", i), 32'(err_frm_h), 32'(vecs[i].e_h));
            checkOutput($sformatf("tbl%0d_err_early_sof", i), 32'(err_early_sof), 32'(vecs[i].e_esof));
            checkOutput($sformatf("tbl%0d_rdy", i), 32'(m_frm_rdy), 32'd1);
        end
        m_frm_val = 1'b0;
        m_frm_sof = 1'b0;
        m_frm_eof = 1'b0;
        m_frm_sol = 1'b0;
        m_frm_eol = 1'b0;
        err_clr   = 1'b0;

        // 4x2 frame at full throughput
        doReset();
        base = got_q.size();
        d0   = done_cnt;
        sendFrame(4, 2, 24'h100);
        waitBeats(base + 8);
        checkFrame("full", base, 4, 2, 24'h100);
        checkOutput("full_done_count", 32'(done_cnt - d0), 32'd1);
        checkErrorsClear("full");

        // Same frame with tready toggling every cycle
        doReset();
        mon_rdy   = 1'b1;
        toggle_en = 1'b1;
        fork
            begin
                while (toggle_en) begin
                    @(posedge clk);
                    #1;
                    s_axi_stream_tready = ~s_axi_stream_tready;
                end
            end
        join_none
        base = got_q.size();
        d0   = done_cnt;
        sendFrame(4, 2, 24'h200);
        waitBeats(base + 8);
        toggle_en = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        s_axi_stream_tready = 1'b1;
        mon_rdy = 1'b0;
        checkFrame("toggle", base, 4, 2, 24'h200);
        checkOutput("toggle_done_count", 32'(done_cnt - d0), 32'd1);
        checkOutput("toggle_rdy_vs_count", 32'(rdy_bad), 32'd0);
        checkOutput("toggle_stall_stable", 32'(stab_bad), 32'd0);
        checkErrorsClear("toggle");

        // Three beats before the first sof are dropped
        doReset();
        base = got_q.size();
        for (int i = 0; i < 3; i++) applyStimulus(24'h3F0 + DW'(i), 1'b0, 1'b0, 1'b0, 1'b0);
        sendFrame(4, 2, 24'h300);
        waitBeats(base + 8);
        checkFrame("presof", base, 4, 2, 24'h300);

        // Reset with two beats buffered
        doReset();
        s_axi_stream_tready = 1'b0;
        applyStimulus(24'h4A0, 1'b1, 1'b0, 1'b1, 1'b0);
        applyStimulus(24'h4A1, 1'b0, 1'b0, 1'b0, 1'b0);
        checkOutput("buf2_tvalid", 32'(s_axi_stream_tvalid), 32'd1);
        checkOutput("buf2_rdy", 32'(m_frm_rdy), 32'd0);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        checkOutput("midrst_tvalid", 32'(s_axi_stream_tvalid), 32'd0);
        checkOutput("midrst_rdy", 32'(m_frm_rdy), 32'd1);
        checkOutput("midrst_tdata", 32'(s_axi_stream_tdata), 32'd0);
        checkOutput("midrst_tuser", 32'(s_axi_stream_tuser), 32'd0);
        s_axi_stream_tready = 1'b1;
        base = got_q.size();
        sendFrame(4, 2, 24'h500);
        waitBeats(base + 8);
        checkFrame("postrst", base, 4, 2, 24'h500);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // Global watchdog so the run always ends
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule

// File: doc/frame2axi_stream.md
FRAME2AXI_STREAM -- requirements
Module: frame2axi_stream

Interface
REQ-001 SHALL have parameter: DATA_WIDTH, 24, pixel data width in bits.
REQ-002 SHALL have port: clk  input  1  system clock; all logic on rising edge.
REQ-003 SHALL have port: rst_n  input  1  reset, synchronous, active-low.
REQ-004 SHALL have port: cfg_img_w  input  12  expected pixels per line.
REQ-005 SHALL have port: cfg_img_h  input  12  expected lines per frame.
REQ-006 SHALL have port: err_clr  input  1  single-cycle pulse that clears all sticky error flags.
REQ-007 SHALL have ports: m_frm_val in 1, m_frm_rdy out 1, m_frm_data in DATA_WIDTH, m_frm_sof in 1, m_frm_eof in 1, m_frm_sol in 1, m_frm_eol in 1; these form the frame-interface input.
REQ-008 SHALL have ports: s_axi_stream_tvalid out 1, s_axi_stream_tready in 1, s_axi_stream_tdata out DATA_WIDTH, s_axi_stream_tuser out 1 (start of frame), s_axi_stream_tlast out 1 (end of line); these form the AXI4-Stream output.
REQ-009 SHALL have ports: frm_done out 1 (one-cycle pulse), err_line_len out 1, err_frm_h out 1, err_early_sof out 1 (all three sticky).

Function
REQ-010 SHALL define input accept as m_frm_val & m_frm_rdy and output transfer as s_axi_stream_tvalid & s_axi_stream_tready.
REQ-011 SHALL buffer beats in a 2-entry FIFO of {data, sof, eol}; m_frm_rdy = (count < 2), driven from registered state only, with no combinational path from tready.
REQ-012 SHALL present an accepted beat on tvalid/tdata/tuser/tlast one cycle after acceptance; the FIFO head SHALL drive the outputs.
REQ-013 SHALL sustain one beat per cycle while tready is held high; simultaneous write and read SHALL leave count unchanged.
REQ-014 SHALL hold tdata/tuser/tlast stable while tvalid is high and tready is low.
REQ-015 SHALL map tuser to the sof of the beat and tlast to the eol of the beat; sol and eof SHALL NOT be forwarded.
REQ-016 SHALL implement FSM states IDLE and ACTIVE.
REQ-017 IDLE: an accepted beat without sof SHALL be discarded (not written to the FIFO); an accepted beat with sof SHALL be written and SHALL move the FSM to ACTIVE.
REQ-018 ACTIVE: every accepted beat SHALL be written; an accepted beat with eof SHALL return the FSM to IDLE and pulse frm_done on the next cycle.
REQ-019 SHALL keep 12-bit counters pix_cnt and line_cnt, updated on input accept: sof sets pix_cnt=1 and line_cnt=0; eol sets pix_cnt=0 and increments line_cnt; otherwise pix_cnt increments; both counters saturate at 4095.
REQ-020 SHALL set err_line_len when an eol beat is accepted with its pixel index != cfg_img_w-1 (12-bit modulo arithmetic).
REQ-021 SHALL set err_frm_h when an eof beat is accepted with line_cnt != cfg_img_h-1.
REQ-022 SHALL handle sof accepted in ACTIVE as follows: set err_early_sof, restart the counters as in REQ-019, remain in ACTIVE, and forward the beat.
REQ-023 SHALL, for a single beat carrying sof, eol and eof, forward it with tuser=1 and tlast=1, run the checks against index 0 and line 0, and go to IDLE.
REQ-024 SHALL give set priority over err_clr when both occur in the same cycle.

Reset
REQ-025 SHALL, on rst_n low at a clock edge, set: FIFO empty, FSM IDLE, counters 0, tvalid 0, tdata 0, tuser 0, tlast 0, frm_done 0, all errors 0, m_frm_rdy 1 from the first cycle after reset.
REQ-026 SHALL discard buffered beats on a reset asserted mid-frame; the first post-reset output beat SHALL carry tuser=1.

Structure
REQ-027 SHALL place the FSM state encoding, FIFO depth constant (2) and counter width (12) in the shared video package.
REQ-028 SHALL implement the FIFO as sub-module frm_skid_fifo (parameterised width, depth 2, synchronous active-low reset).

Verification
REQ-029 SHALL cover: 4x2 frame, tready=1 -> 8 beats out, tuser on beat 0, tlast on beats 3 and 7, frm_done once, no errors.
REQ-030 SHALL cover: same frame, tready toggling 1-0 each cycle -> identical data order, m_frm_rdy low only when count=2, no loss or duplication.
REQ-031 SHALL cover: 3 non-sof beats before sof -> all 3 dropped, first output beat has tuser=1.
REQ-032 SHALL cover: cfg_img_w=4, line of 3 beats -> err_line_len=1 and held; err_clr pulse -> 0.
REQ-033 SHALL cover: sof at pixel 2 of line 1 -> err_early_sof=1, counters restart, beat forwarded with tuser=1.
REQ-034 SHALL cover: rst_n low for 1 cycle with 2 beats buffered -> tvalid=0 next cycle, FIFO empty, m_frm_rdy=1.
